// File: rtl/bch_decode_ctrl.sv
// Sequencer for the BCH(31,k) decoder: syndrome -> BM -> Chien, with a per-stage watchdog.
// Accept-to-status is 3 cycles on a clean word; status is held until out_ready and no new job is taken meanwhile.
module bch_decode_ctrl #(
  parameter int T          = 3,
  parameter int LW         = 4,
  parameter int TIMEOUT    = 63,
  parameter int BM_RST_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          syn_start,
  input  logic          syn_done,
  input  logic          syn_zero,
  output logic          bm_rst,
  input  logic          bm_done,
  input  logic [LW-1:0] bm_L,
  output logic          chien_start,
  input  logic          chien_done,
  input  logic [LW-1:0] chien_nerr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_status,
  output logic [LW-1:0] out_nerr,
  output logic          busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int RCW = (BM_RST_CYC > 1) ? $clog2(BM_RST_CYC) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYN    = 3'd1;
  localparam logic [2:0] S_BM_RST = 3'd2;
  localparam logic [2:0] S_BM_RUN = 3'd3;
  localparam logic [2:0] S_CHIEN  = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  localparam logic [1:0] ST_CLEAN   = 2'd0;
  localparam logic [1:0] ST_FIXED   = 2'd1;
  localparam logic [1:0] ST_UNCORR  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  logic [2:0]    state_q, state_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic [LW-1:0] l_q, l_d;
  logic [1:0]    status_q, status_d;
  logic [LW-1:0] nerr_q, nerr_d;
  logic          syn_start_q, chien_start_q, bm_rst_q, in_ready_q, out_valid_q, busy_q;
  logic          wd_hit, wd_counting;

  assign wd_hit      = (wd_q == WDW'(TIMEOUT - 1));
  assign wd_counting = (state_q == S_SYN) || (state_q == S_BM_RUN) || (state_q == S_CHIEN);

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    status_d = status_q;
    nerr_d   = nerr_q;
    rc_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) state_d = S_SYN;
      end
      // A done seen while our own start pulse is still out belongs to the previous job.
      S_SYN: begin
        if (syn_done && !syn_start_q) begin
          if (syn_zero) begin
            status_d = ST_CLEAN;
            nerr_d   = '0;
            state_d  = S_REPORT;
          end else begin
            state_d = S_BM_RST;
          end
        end else if (wd_hit) begin
          status_d = ST_TIMEOUT;
          nerr_d   = '0;
          state_d  = S_REPORT;
        end
      end
      S_BM_RST: begin
        rc_d = rc_q + RCW'(1);
        if (rc_q == RCW'(BM_RST_CYC - 1)) state_d = S_BM_RUN;
      end
      S_BM_RUN: begin
        if (bm_done) begin
          l_d = bm_L;
          if (bm_L > LW'(T)) begin
            status_d = ST_UNCORR;
            nerr_d   = '0;
            state_d  = S_REPORT;
          end else begin
            state_d = S_CHIEN;
          end
        end else if (wd_hit) begin
          status_d = ST_TIMEOUT;
          nerr_d   = '0;
          state_d  = S_REPORT;
        end
      end
      S_CHIEN: begin
        if (chien_done && !chien_start_q) begin
          if ((chien_nerr == l_q) && (l_q != '0)) begin
            status_d = ST_FIXED;
            nerr_d   = l_q;
          end else begin
            status_d = ST_UNCORR;
            nerr_d   = '0;
          end
          state_d = S_REPORT;
        end else if (wd_hit) begin
          status_d = ST_TIMEOUT;
          nerr_d   = '0;
          state_d  = S_REPORT;
        end
      end
      S_REPORT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    wd_d = ((state_d != state_q) || !wd_counting) ? '0 : wd_q + WDW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wd_q          <= '0;
      rc_q          <= '0;
      l_q           <= '0;
      status_q      <= ST_CLEAN;
      nerr_q        <= '0;
      syn_start_q   <= 1'b0;
      chien_start_q <= 1'b0;
      bm_rst_q      <= 1'b1;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      rc_q          <= rc_d;
      l_q           <= l_d;
      status_q      <= status_d;
      nerr_q        <= nerr_d;
      syn_start_q   <= (state_q == S_IDLE) && (state_d == S_SYN);
      chien_start_q <= (state_q == S_BM_RUN) && (state_d == S_CHIEN);
      // BM only runs while we are waiting on it or on Chien; any other state holds it in reset.
      bm_rst_q      <= !((state_d == S_BM_RUN) || (state_d == S_CHIEN));
      in_ready_q    <= (state_d == S_IDLE);
      out_valid_q   <= (state_d == S_REPORT);
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign in_ready    = in_ready_q;
  assign syn_start   = syn_start_q;
  assign chien_start = chien_start_q;
  assign bm_rst      = bm_rst_q;
  assign out_valid   = out_valid_q;
  assign out_status  = status_q;
  assign out_nerr    = nerr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bch_decode_ctrl.sv
// Scoreboard bench for bch_decode_ctrl with reactive models of the syndrome, BM and Chien units.
module tb_bch_decode_ctrl;
  localparam int T = 3, LW = 4, TIMEOUT = 63, BM_RST_CYC = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic syn_start, syn_done, syn_zero;
  logic bm_rst, bm_done;
  logic [LW-1:0] bm_L;
  logic chien_start, chien_done;
  logic [LW-1:0] chien_nerr;
  logic out_valid, out_ready = 1'b1;
  logic [1:0] out_status;
  logic [LW-1:0] out_nerr;
  logic busy;

  bch_decode_ctrl #(.T(T), .LW(LW), .TIMEOUT(TIMEOUT), .BM_RST_CYC(BM_RST_CYC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .syn_start(syn_start), .syn_done(syn_done), .syn_zero(syn_zero),
    .bm_rst(bm_rst), .bm_done(bm_done), .bm_L(bm_L),
    .chien_start(chien_start), .chien_done(chien_done), .chien_nerr(chien_nerr),
    .out_valid(out_valid), .out_ready(out_ready), .out_status(out_status),
    .out_nerr(out_nerr), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stage models: configuration set by the stimulus before each job.
  bit cfg_zero = 1'b0, cfg_chien_hang = 1'b0;
  int cfg_lat = 1;
  logic [LW-1:0] cfg_L = '0, cfg_cn = '0;
  bit syn_pend = 1'b0, ch_pend = 1'b0;
  int bm_cnt = 0;

  initial begin
    syn_done = 1'b0; syn_zero = 1'b0;
    forever begin
      @(negedge clk);
      syn_done = syn_pend;
      syn_zero = syn_pend & cfg_zero;
      syn_pend = syn_start & reset;
    end
  end

  initial begin
    bm_done = 1'b0; bm_L = '0;
    forever begin
      @(negedge clk);
      if (bm_rst) begin
        bm_cnt = 0; bm_done = 1'b0;
      end else begin
        bm_cnt++;
        if (bm_cnt == cfg_lat) begin bm_done = 1'b1; bm_L = cfg_L; end
      end
    end
  end

  initial begin
    chien_done = 1'b0; chien_nerr = '0;
    forever begin
      @(negedge clk);
      chien_done = ch_pend;
      chien_nerr = ch_pend ? cfg_cn : '0;
      ch_pend = chien_start & reset & !cfg_chien_hang;
    end
  end

  typedef struct {logic [1:0] st; logic [LW-1:0] nerr; int acc; int lat;} exp_t;
  exp_t sb[$];
  int n_done = 0, syn_cnt = 0, chien_cnt = 0, bm_falls = 0, bm_fall_cyc = -1, first_vld = -1;
  bit prev_syn = 1'b0, prev_ch = 1'b0, prev_bm = 1'b1;

  // Monitor: pulse properties, bm_rst release tracking, scoreboard pop on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (syn_start && chien_start) chk("pulse_overlap", 1, 0);
        if (syn_start && prev_syn) chk("syn_start_width", 2, 1);
        if (chien_start && prev_ch) chk("chien_start_width", 2, 1);
        if (syn_start) syn_cnt++;
        if (chien_start) chien_cnt++;
        if (prev_bm && !bm_rst) begin bm_falls++; bm_fall_cyc = cyc; end
        if (out_valid && first_vld < 0) first_vld = cyc;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_status", 1, 0);
          else begin
            e = sb.pop_front();
            chk("status", out_status, e.st);
            chk("nerr", out_nerr, e.nerr);
            chk("bm_rst_in_report", bm_rst, 1);
            if (e.lat >= 0) chk("latency", first_vld - e.acc, e.lat);
          end
          n_done++;
          first_vld = -1;
        end
        prev_syn = syn_start; prev_ch = chien_start; prev_bm = bm_rst;
      end else begin
        first_vld = -1; prev_syn = 1'b0; prev_ch = 1'b0; prev_bm = 1'b1;
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_syn_start", syn_start, 0);
    chk("rst_chien_start", chien_start, 0);
    chk("rst_bm_rst", bm_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_status", out_status, 0);
    chk("rst_out_nerr", out_nerr, 0);
  endtask

  // Called at posedge+1; returns with the DUT in the cycle after acceptance.
  task automatic issue(input logic [1:0] es, input logic [LW-1:0] en, input int elat,
                       input bit push, output int acc);
    int g = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    acc = cyc;
    if (push) sb.push_back('{es, en, acc, elat});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("syn_start_after_accept", syn_start, 1);
    chk("busy_after_accept", busy, 1);
    chk("in_ready_after_accept", in_ready, 0);
  endtask

  int jobs = 0;
  task automatic wait_done();
    int g = 0;
    while (n_done < jobs && g < 300) begin @(posedge clk); #1; g++; end
    chk("job_complete", n_done >= jobs, 1);
  endtask

  task automatic run_job(input bit z, input int lat, input logic [LW-1:0] L, input logic [LW-1:0] cn,
                         input logic [1:0] es, input logic [LW-1:0] en, input int elat,
                         input int ech, input int ebl);
    int s0, c0, f0, acc;
    cfg_zero = z; cfg_lat = lat; cfg_L = L; cfg_cn = cn;
    s0 = syn_cnt; c0 = chien_cnt; f0 = bm_falls;
    issue(es, en, elat, 1'b1, acc);
    jobs++;
    wait_done();
    chk("syn_pulses", syn_cnt - s0, 1);
    chk("chien_pulses", chien_cnt - c0, ech);
    if (ebl < 0) chk("bm_rst_never_released", bm_falls - f0, 0);
    else chk("bm_rst_release_cycle", bm_fall_cyc - acc, ebl);
  endtask

  localparam int LAT_CLEAN = 3;
  localparam int BL = 3 + BM_RST_CYC;

  initial begin
    int acc, g, s0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 1'b1;
    @(posedge clk); #1;

    // Clean word.
    run_job(1, 1, 0, 0, 2'd0, 0, LAT_CLEAN, 0, -1);
    // Corrected: two errors, then one error with a slower BM, then L == T.
    run_job(0, 1, 2, 2, 2'd1, 2, BL + 1 + 2, 1, BL);
    run_job(0, 3, 1, 1, 2'd1, 1, BL + 3 + 2, 1, BL);
    run_job(0, 1, 3, 3, 2'd1, 3, BL + 1 + 2, 1, BL);
    // Uncorrectable: L > T skips Chien; root count mismatch; L == 0.
    run_job(0, 1, 4, 0, 2'd2, 0, BL + 1, 0, BL);
    run_job(0, 1, 3, 1, 2'd2, 0, BL + 1 + 2, 1, BL);
    run_job(0, 2, 0, 0, 2'd2, 0, BL + 2 + 2, 1, BL);
    // BM never finishes -> timeout; BM finishing on the last watchdog cycle -> normal.
    run_job(0, 0, 2, 2, 2'd3, 0, BL + TIMEOUT, 0, BL);
    run_job(0, TIMEOUT, 2, 2, 2'd1, 2, BL + TIMEOUT + 2, 1, BL);

    // Backpressure: status held, new job refused until the cycle after the handshake.
    cfg_zero = 0; cfg_lat = 1; cfg_L = 2; cfg_cn = 2;
    s0 = syn_cnt;
    out_ready = 1'b0;
    issue(2'd1, 2, -1, 1'b1, acc);
    jobs++;
    g = 0;
    while (!out_valid && g < 50) begin @(posedge clk); #1; g++; end
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_status", out_status, 1);
      chk("bp_nerr", out_nerr, 2);
      chk("bp_in_ready", in_ready, 0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp_no_accept", syn_cnt - s0, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_out_valid_dropped", out_valid, 0);
    chk("bp_in_ready_after_hs", in_ready, 1);
    chk("bp_no_accept_on_hs", syn_cnt - s0, 1);
    sb.push_back('{2'd1, 4'd2, cyc, BL + 1 + 2});
    jobs++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accept", syn_start, 1);
    wait_done();

    // Asynchronous reset in the middle of Chien.
    cfg_chien_hang = 1'b1;
    s0 = n_done;
    issue(2'd1, 2, -1, 1'b0, acc);
    g = 0;
    while (!chien_start && g < 50) begin @(posedge clk); #1; g++; end
    chk("chien_start_seen", chien_start, 1);
    @(posedge clk); #1;
    chk("mid_chien_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    cfg_chien_hang = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("no_status_for_aborted", n_done - s0, 0);
    run_job(0, 1, 2, 2, 2'd1, 2, BL + 1 + 2, 1, BL);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
